// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the timer_counter block: the counting-mode encoding
// used on the control bus and inside the counter state machine.
// ---------------------------------------------------------------------------
package timer_pkg;

    // Counting modes as written by software into the mode field.
    typedef enum logic [1:0] {
        MODE_STOP   = 2'd0,
        MODE_UP     = 2'd1,
        MODE_CONT   = 2'd2,
        MODE_UPDOWN = 2'd3
    } mode_t;

endpackage

// File: rtl/timer_counter_if.sv
// ---------------------------------------------------------------------------
// timer_counter_if
// Control/status bundle between the bus-side registers (master) and the timer
// core (slave).
//   master drives : mode, div_sel, clr, period, cmp, ack_wrap, ack_cmp
//   slave drives  : count, dir_down, tick, wrap_flag, cmp_flag, cmp_out
// Parameters WIDTH and DIV_W must match the timer_counter instance.
// ---------------------------------------------------------------------------
interface timer_counter_if
    import timer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIV_W = 2
);
    mode_t              mode;
    logic [DIV_W-1:0]   div_sel;
    logic               clr;
    logic [WIDTH-1:0]   period;
    logic [WIDTH-1:0]   cmp;
    logic               ack_wrap;
    logic               ack_cmp;

    logic [WIDTH-1:0]   count;
    logic               dir_down;
    logic               tick;
    logic               wrap_flag;
    logic               cmp_flag;
    logic               cmp_out;

    modport master (
        output mode, div_sel, clr, period, cmp, ack_wrap, ack_cmp,
        input  count, dir_down, tick, wrap_flag, cmp_flag, cmp_out
    );

    modport slave (
        input  mode, div_sel, clr, period, cmp, ack_wrap, ack_cmp,
        output count, dir_down, tick, wrap_flag, cmp_flag, cmp_out
    );
endinterface

// File: rtl/timer_prescaler.sv
// ---------------------------------------------------------------------------
// timer_prescaler
// Clock divider for the timer. Produces adv once every 2^div_sel enabled
// cycles.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   en      : counting enabled (divider held at 0 when low)
//   clr     : synchronous clear of the divider
//   div_sel : divide select, ratio 2^div_sel
//   adv     : combinational advance strobe, consumed by the counter register
// ---------------------------------------------------------------------------
module timer_prescaler #(
    parameter int DIV_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div_sel,
    output logic             adv
);
    // Wide enough to hold the largest terminal, 2^(2^DIV_W - 1) - 1.
    localparam int PRE_W = (1 << DIV_W) - 1;

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] term;

    // Terminal value 2^div_sel - 1 built as a thermometer mask.
    always_comb begin
        term = '0;
        for (int i = 0; i < PRE_W; i++) begin
            term[i] = (i < int'(div_sel));
        end
    end

    // Using >= rather than == lets a lowered div_sel take effect at once
    // instead of waiting for the divider to roll over.
    assign adv = en & ~clr & (pre >= term);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if (clr || !en || adv) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end
endmodule

// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
// Programmable timer: prescaled counter with STOP/UP/CONT/UPDOWN modes, a
// period register, a compare channel and sticky event flags.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : timer_counter_if.slave
//         inputs  mode, div_sel, clr, period, cmp, ack_wrap, ack_cmp
//         outputs count, dir_down, tick, wrap_flag, cmp_flag, cmp_out
// All outputs are registered.
// ---------------------------------------------------------------------------
module timer_counter
    import timer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIV_W = 2
) (
    input  logic           clk,
    input  logic           rst,
    timer_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_COUNT = '1;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic             adv;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] next_count;
    logic             dir_q;
    logic             next_dir;
    logic             wrap_evt;
    logic             cmp_evt;
    logic             tick_q;
    logic             wrap_q;
    logic             cmp_flag_q;
    logic             cmp_out_q;

    timer_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.mode != MODE_STOP),
        .clr     (bus.clr),
        .div_sel (bus.div_sel),
        .adv     (adv)
    );

    // Next count/direction and events for the current advance. Outside
    // UPDOWN the direction is forced to up so a later UPDOWN entry rises.
    always_comb begin
        next_count = count_q;
        next_dir   = (bus.mode == MODE_UPDOWN) ? dir_q : 1'b0;
        wrap_evt   = 1'b0;
        if (adv) begin
            case (bus.mode)
                MODE_UP: begin
                    if (count_q >= bus.period) begin
                        next_count = '0;
                        wrap_evt   = 1'b1;
                    end else begin
                        next_count = count_q + ONE;
                    end
                end
                MODE_CONT: begin
                    next_count = count_q + ONE;
                    wrap_evt   = (count_q == MAX_COUNT);
                end
                MODE_UPDOWN: begin
                    if (dir_q && count_q != '0) begin
                        next_count = count_q - ONE;
                        next_dir   = 1'b1;
                        wrap_evt   = (count_q == ONE);
                    end else if (count_q < bus.period) begin
                        next_count = count_q + ONE;
                        next_dir   = 1'b0;
                    end else if (count_q == '0) begin
                        // period == 0: park at zero, no events.
                        next_dir   = 1'b0;
                    end else begin
                        // At or above the peak: turn around.
                        next_count = count_q - ONE;
                        next_dir   = 1'b1;
                        wrap_evt   = (count_q == ONE);
                    end
                end
                default: begin
                end
            endcase
        end
        cmp_evt = adv && (next_count == bus.cmp);
    end

    // Counter state, registered decode and sticky flags. A flag event in the
    // same cycle as its acknowledge wins so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            dir_q      <= 1'b0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            cmp_flag_q <= 1'b0;
            cmp_out_q  <= 1'b0;
        end else begin
            if (bus.clr) begin
                count_q   <= '0;
                dir_q     <= 1'b0;
                tick_q    <= 1'b0;
                cmp_out_q <= (bus.cmp == '0);
            end else begin
                count_q   <= next_count;
                dir_q     <= next_dir;
                tick_q    <= adv;
                cmp_out_q <= (next_count == bus.cmp);
            end
            wrap_q     <= wrap_evt | (wrap_q & ~bus.ack_wrap);
            cmp_flag_q <= cmp_evt | (cmp_flag_q & ~bus.ack_cmp);
        end
    end

    assign bus.count     = count_q;
    assign bus.dir_down  = dir_q;
    assign bus.tick      = tick_q;
    assign bus.wrap_flag = wrap_q;
    assign bus.cmp_flag  = cmp_flag_q;
    assign bus.cmp_out   = cmp_out_q;
endmodule

// File: tb/tb_timer_counter.sv
// ---------------------------------------------------------------------------
// tb_timer_counter
// Directed bench for timer_counter (WIDTH=4, DIV_W=2). The stimulus process
// drives inputs shortly after a rising edge and queues the outputs expected
// after the following edge; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_timer_counter;
    import timer_pkg::*;

    localparam int WIDTH = 4;
    localparam int DIV_W = 2;

    typedef struct {
        int    cyc;
        string name;
        int    count;
        int    dir;
        int    tick;
        int    wrap;
        int    cmpf;
        int    cmpo;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t sb[$];
    int   edge_count = 0;
    int   compared   = 0;
    int   mismatched = 0;

    int up_seq[6]    = '{1, 2, 3, 4, 0, 1};
    int ud_cnt[8]    = '{1, 2, 3, 2, 1, 0, 1, 2};
    int ud_dir[8]    = '{0, 0, 0, 1, 1, 1, 0, 0};

    timer_counter_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

    timer_counter #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_count++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Queue the outputs expected after the next rising edge, then step to it.
    task automatic applyStimulus(input string name, input int c, input int d,
                                 input int t, input int w, input int cf,
                                 input int co);
        exp_t e;
        e.cyc   = edge_count + 1;
        e.name  = name;
        e.count = c;
        e.dir   = d;
        e.tick  = t;
        e.wrap  = w;
        e.cmpf  = cf;
        e.cmpo  = co;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare every expectation that has come due.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= edge_count) begin
            e = sb.pop_front();
            if (e.cyc != edge_count)
                checkOutput({e.name, ".cycle"}, edge_count, e.cyc);
            checkOutput({e.name, ".count"},     32'(bus.count), e.count);
            checkOutput({e.name, ".dir_down"},  32'(bus.dir_down), e.dir);
            checkOutput({e.name, ".tick"},      32'(bus.tick), e.tick);
            checkOutput({e.name, ".wrap_flag"}, 32'(bus.wrap_flag), e.wrap);
            checkOutput({e.name, ".cmp_flag"},  32'(bus.cmp_flag), e.cmpf);
            checkOutput({e.name, ".cmp_out"},   32'(bus.cmp_out), e.cmpo);
        end
    end

    initial begin
        rst          = 1'b1;
        bus.mode     = MODE_STOP;
        bus.div_sel  = 2'd0;
        bus.clr      = 1'b0;
        bus.period   = 4'd0;
        bus.cmp      = 4'd15;
        bus.ack_wrap = 1'b0;
        bus.ack_cmp  = 1'b0;
        @(posedge clk);
        #2;

        // Reset state
        applyStimulus("rst0", 0, 0, 0, 0, 0, 0);
        applyStimulus("rst1", 0, 0, 0, 0, 0, 0);

        // UP, period 4, no prescale
        rst        = 1'b0;
        bus.mode   = MODE_UP;
        bus.period = 4'd4;
        for (int i = 0; i < 6; i++)
            applyStimulus("up4", up_seq[i], 0, 1, (i >= 4) ? 1 : 0, 0, 0);
        bus.ack_wrap = 1'b1;
        applyStimulus("up4_ack", 2, 0, 1, 0, 0, 0);
        bus.ack_wrap = 1'b0;

        // CONT, divide by 4, full 4-bit roll-over twice
        bus.clr     = 1'b1;
        bus.mode    = MODE_CONT;
        bus.div_sel = 2'd2;
        applyStimulus("cont_clr", 0, 0, 0, 0, 0, 0);
        bus.clr = 1'b0;
        for (int k = 1; k <= 129; k++) begin
            bus.ack_wrap = (k == 65 || k == 128);
            applyStimulus("cont", (k / 4) % 16, 0, (k % 4 == 0) ? 1 : 0,
                          (k == 64 || k >= 128) ? 1 : 0, (k >= 60) ? 1 : 0,
                          ((k / 4) % 16 == 15) ? 1 : 0);
        end
        bus.ack_wrap = 1'b0;

        // UPDOWN, period 3
        bus.clr      = 1'b1;
        bus.mode     = MODE_UPDOWN;
        bus.div_sel  = 2'd0;
        bus.period   = 4'd3;
        bus.ack_wrap = 1'b1;
        bus.ack_cmp  = 1'b1;
        applyStimulus("ud_clr", 0, 0, 0, 0, 0, 0);
        bus.clr      = 1'b0;
        bus.ack_wrap = 1'b0;
        bus.ack_cmp  = 1'b0;
        for (int i = 0; i < 8; i++)
            applyStimulus("ud3", ud_cnt[i], ud_dir[i], 1, (i >= 5) ? 1 : 0, 0, 0);

        // UP, period lowered below count, then period 0
        bus.clr      = 1'b1;
        bus.mode     = MODE_UP;
        bus.period   = 4'd10;
        bus.ack_wrap = 1'b1;
        bus.ack_cmp  = 1'b1;
        applyStimulus("up10_clr", 0, 0, 0, 0, 0, 0);
        bus.clr      = 1'b0;
        bus.ack_wrap = 1'b0;
        bus.ack_cmp  = 1'b0;
        for (int k = 1; k <= 7; k++)
            applyStimulus("up10", k, 0, 1, 0, 0, 0);
        bus.period = 4'd5;
        applyStimulus("shrink", 0, 0, 1, 1, 0, 0);
        bus.period   = 4'd0;
        bus.div_sel  = 2'd1;
        bus.ack_wrap = 1'b1;
        applyStimulus("p0_ack1", 0, 0, 0, 0, 0, 0);
        bus.ack_wrap = 1'b0;
        applyStimulus("p0_adv1", 0, 0, 1, 1, 0, 0);
        bus.ack_wrap = 1'b1;
        applyStimulus("p0_ack2", 0, 0, 0, 0, 0, 0);
        bus.ack_wrap = 1'b0;
        applyStimulus("p0_adv2", 0, 0, 1, 1, 0, 0);

        // Compare channel
        bus.clr      = 1'b1;
        bus.period   = 4'd9;
        bus.cmp      = 4'd6;
        bus.div_sel  = 2'd0;
        bus.ack_wrap = 1'b1;
        bus.ack_cmp  = 1'b1;
        applyStimulus("cmp_clr", 0, 0, 0, 0, 0, 0);
        bus.clr      = 1'b0;
        bus.ack_wrap = 1'b0;
        bus.ack_cmp  = 1'b0;
        for (int k = 1; k <= 8; k++)
            applyStimulus("cmp_up", k, 0, 1, 0, (k >= 6) ? 1 : 0, (k == 6) ? 1 : 0);
        bus.mode    = MODE_STOP;
        bus.ack_cmp = 1'b1;
        applyStimulus("stop_ack", 8, 0, 0, 0, 0, 0);
        bus.ack_cmp = 1'b0;
        bus.cmp     = 4'd8;
        applyStimulus("stop_cmp", 8, 0, 0, 0, 0, 1);
        applyStimulus("stop_hold", 8, 0, 0, 0, 0, 1);

        // clr mid-descent keeps flags; rst mid-count clears everything
        bus.clr    = 1'b1;
        bus.mode   = MODE_UPDOWN;
        bus.period = 4'd6;
        bus.cmp    = 4'd6;
        applyStimulus("ud6_clr", 0, 0, 0, 0, 0, 0);
        bus.clr = 1'b0;
        for (int k = 1; k <= 6; k++)
            applyStimulus("ud6_up", k, 0, 1, 0, (k == 6) ? 1 : 0, (k == 6) ? 1 : 0);
        applyStimulus("ud6_down", 5, 1, 1, 0, 1, 0);
        bus.clr = 1'b1;
        applyStimulus("ud6_clr_mid", 0, 0, 0, 0, 1, 0);
        bus.clr = 1'b0;
        applyStimulus("ud6_rise", 1, 0, 1, 0, 1, 0);
        rst = 1'b1;
        applyStimulus("rst_mid", 0, 0, 0, 0, 0, 0);
        rst      = 1'b0;
        bus.mode = MODE_STOP;
        applyStimulus("rst_after", 0, 0, 0, 0, 0, 0);

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        #1;
        if (sb.size() != 0)
            checkOutput("drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
